// File: rtl/calc_sequencer.sv
// Calculator control FSM: sequences keypad entry into A, operator and B, launches the ALU
// and waits for completion (or times out), driving the display enables and error flag.
module calc_sequencer #(
  parameter int ALU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       alu_done,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] op,
  output logic       flag,
  output logic       en_a,
  output logic       en_b,
  output logic       alu_start,
  output logic       result_valid,
  output logic       error
);

  localparam int CW = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EQ   = 3'd3,
    S_RUN  = 3'd4,
    S_SHOW = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    a_nxt, b_nxt;
  logic [1:0]    op_nxt;
  logic          flag_nxt, en_a_nxt, en_b_nxt, start_nxt, rv_nxt, err_nxt;
  logic          is_digit, is_oper, is_eq, is_clr;
  logic [1:0]    key_op;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_oper  = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = key_valid && (key_code == 4'd14);
  assign is_clr   = key_valid && (key_code == 4'd15);
  // Codes 10..13 map to op 0..3; adding 2 modulo 4 to the low bits is the same as subtracting 10.
  assign key_op   = key_code[1:0] + 2'd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_A;
      cnt          <= '0;
      a            <= '0;
      b            <= '0;
      op           <= '0;
      flag         <= 1'b0;
      en_a         <= 1'b0;
      en_b         <= 1'b0;
      alu_start    <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      a            <= a_nxt;
      b            <= b_nxt;
      op           <= op_nxt;
      flag         <= flag_nxt;
      en_a         <= en_a_nxt;
      en_b         <= en_b_nxt;
      alu_start    <= start_nxt;
      result_valid <= rv_nxt;
      error        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    op_nxt    = op;
    flag_nxt  = flag;
    en_a_nxt  = en_a;
    en_b_nxt  = en_b;
    start_nxt = 1'b0;
    rv_nxt    = result_valid;
    err_nxt   = error;

    // Clear (and any illegal encoding) returns every register to its reset value.
    if (is_clr || state == 3'd7) begin
      state_nxt = S_A;
      cnt_nxt   = '0;
      a_nxt     = '0;
      b_nxt     = '0;
      op_nxt    = '0;
      flag_nxt  = 1'b0;
      en_a_nxt  = 1'b0;
      en_b_nxt  = 1'b0;
      rv_nxt    = 1'b0;
      err_nxt   = 1'b0;
    end else begin
      case (state)
        S_A: if (is_digit) begin
          a_nxt     = key_code;
          en_a_nxt  = 1'b1;
          state_nxt = S_OP;
        end
        S_OP: begin
          if (is_digit) a_nxt = key_code;
          else if (is_oper) begin
            op_nxt    = key_op;
            flag_nxt  = 1'b1;
            state_nxt = S_B;
          end
        end
        S_B: begin
          if (is_digit) begin
            b_nxt     = key_code;
            en_b_nxt  = 1'b1;
            state_nxt = S_EQ;
          end else if (is_oper) op_nxt = key_op;
        end
        S_EQ: begin
          if (is_digit) b_nxt = key_code;
          else if (is_oper) op_nxt = key_op;
          else if (is_eq) begin
            if (op == 2'b11 && b == 4'd0) begin
              err_nxt   = 1'b1;
              en_a_nxt  = 1'b0;
              en_b_nxt  = 1'b0;
              state_nxt = S_ERR;
            end else begin
              start_nxt = 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_RUN;
            end
          end
        end
        // Completion is checked before expiry so a done on the last cycle still counts.
        S_RUN: begin
          if (alu_done) begin
            rv_nxt    = 1'b1;
            state_nxt = S_SHOW;
          end else if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            en_a_nxt  = 1'b0;
            en_b_nxt  = 1'b0;
            state_nxt = S_ERR;
          end else cnt_nxt = cnt + 1'b1;
        end
        S_SHOW: if (is_digit) begin
          rv_nxt    = 1'b0;
          a_nxt     = key_code;
          b_nxt     = '0;
          flag_nxt  = 1'b0;
          en_a_nxt  = 1'b1;
          en_b_nxt  = 1'b0;
          state_nxt = S_OP;
        end
        S_ERR: begin
          err_nxt  = 1'b1;
          en_a_nxt = 1'b0;
          en_b_nxt = 1'b0;
          rv_nxt   = 1'b0;
        end
        default: state_nxt = S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected ALU-start/done/error events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_calc_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid, alu_done;
  logic [3:0] key_code;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       flag, en_a, en_b, alu_start, result_valid, error;

  typedef struct {
    int kind;   // 0 start, 1 result shown, 2 error
    int ea;
    int eb;
    int eop;
    int lat;    // cycles from alu_start to error, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  logic prev_rv = 1'b0, prev_err = 1'b0;

  calc_sequencer #(.ALU_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .a(a), .b(b), .op(op), .flag(flag), .en_a(en_a),
    .en_b(en_b), .alu_start(alu_start), .result_valid(result_valid), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int ea, input int eb, input int eop, input int lat);
    ev_t e;
    e.kind = kind; e.ea = ea; e.eb = eb; e.eop = eop; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind, input int lat);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind != 2) begin
          check("ev_a", a, e.ea);
          check("ev_b", b, e.eb);
          check("ev_op", op, e.eop);
        end else if (e.lat >= 0) begin
          check("ev_timeout_latency", lat, e.lat);
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (alu_start) begin
        start_cyc = cyc;
        check_event(0, 0);
      end
      if (result_valid && !prev_rv) check_event(1, 0);
      if (error && !prev_err) check_event(2, cyc - start_cyc);
      prev_rv  = result_valid;
      prev_err = error;
    end
  end

  task automatic apply_key(input int code);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = 4'(code);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic pulse_done(input int n);
    repeat (n) @(posedge clk);
    #1 alu_done = 1'b1;
    @(posedge clk);
    #1 alu_done = 1'b0;
  endtask

  task automatic wait_start(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (alu_start) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_start: got no alu_start expected one within %0d cycles", maxc);
    end
  endtask

  task automatic wait_error(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (error) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_error: got error=0 expected 1 within %0d cycles", maxc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_a"}, a, 0);
    check({tag, "_b"}, b, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_flag"}, flag, 0);
    check({tag, "_en_a"}, en_a, 0);
    check({tag, "_en_b"}, en_b, 0);
    check({tag, "_alu_start"}, alu_start, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'd0; alu_done = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // 3 + 4, ALU finishes three cycles after start
    push_ev(0, 3, 4, 0, -1);
    apply_key(3);
    apply_key(10);
    @(negedge clk);
    check("add_flag", flag, 1);
    check("add_en_a", en_a, 1);
    apply_key(4);
    apply_key(14);
    wait_start(20);
    push_ev(1, 3, 4, 0, -1);
    pulse_done(3);
    @(negedge clk);
    check("add_result_valid", result_valid, 1);

    // New calculation from the result screen: 6 * 3
    apply_key(6);
    @(negedge clk);
    check("show_rv", result_valid, 0);
    check("show_a", a, 6);
    check("show_b", b, 0);
    check("show_flag", flag, 0);
    check("show_en_a", en_a, 1);
    check("show_en_b", en_b, 0);
    push_ev(0, 6, 3, 2, -1);
    apply_key(12);
    apply_key(3);
    apply_key(14);
    wait_start(20);
    push_ev(1, 6, 3, 2, -1);
    pulse_done(1);
    @(negedge clk);
    check("mul_result_valid", result_valid, 1);
    apply_key(15);
    @(negedge clk);
    check_reset_values("clear1");

    // Divide by zero never starts the ALU
    push_ev(2, 0, 0, 0, -1);
    apply_key(7);
    apply_key(13);
    apply_key(0);
    apply_key(14);
    @(negedge clk);
    check("div0_error", error, 1);
    check("div0_en_a", en_a, 0);
    check("div0_en_b", en_b, 0);
    apply_key(3);
    @(negedge clk);
    check("err_holds_on_digit", error, 1);
    apply_key(15);
    @(negedge clk);
    check_reset_values("clear2");

    // ALU never answers: error exactly TO cycles after alu_start
    push_ev(0, 2, 5, 1, -1);
    push_ev(2, 0, 0, 0, TO);
    apply_key(2);
    apply_key(11);
    apply_key(5);
    apply_key(14);
    wait_start(20);
    wait_error(TO + 10);
    check("timeout_en_a", en_a, 0);
    apply_key(15);

    // Done arriving on the final timeout cycle wins
    push_ev(0, 1, 1, 0, -1);
    push_ev(1, 1, 1, 0, -1);
    apply_key(1);
    apply_key(10);
    apply_key(1);
    apply_key(14);
    wait_start(20);
    pulse_done(TO - 1);
    @(negedge clk);
    check("edge_done_rv", result_valid, 1);
    check("edge_done_error", error, 0);
    apply_key(15);

    // Overwrite paths, then async reset in the middle of the run
    push_ev(0, 2, 8, 1, -1);
    apply_key(1);
    apply_key(2);
    apply_key(10);
    apply_key(11);
    apply_key(9);
    apply_key(8);
    apply_key(14);
    wait_start(20);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;
    pulse_done(1);
    repeat (TO + 4) @(negedge clk);
    check("late_done_rv", result_valid, 0);
    check("late_done_error", error, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
